// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC source encoding, fetch FSM states, opcode field bounds and
// the default reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SRC_BRANCH = 2'b00,
    PC_SRC_RIND   = 2'b01,
    PC_SRC_INC    = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    FETCH_REQ,
    FETCH_WAIT,
    HOLD
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 11;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for a retiring instruction; result is always halfword aligned.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [15:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [15:0] br_target,
  input  logic [15:0] rind_target,
  output logic [15:0] next_pc
);

  logic [15:0] sel;

  always_comb begin
    sel = pc;
    unique case (pc_src_e'(pc_src))
      PC_SRC_BRANCH: sel = br_target;
      PC_SRC_RIND:   sel = rind_target;
      PC_SRC_INC:    sel = pc + 16'd2;
      PC_SRC_HOLD:   sel = pc;
    endcase
  end

  assign next_pc = {sel[15:1], 1'b0};

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests instructions over a shared memory port, holds them in ir until
// the instruction retires, then moves the PC and counts the retirement.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        data_busy,
  input  logic        advance,
  input  logic [1:0]  pc_src,
  input  logic [15:0] br_target,
  input  logic [15:0] rind_target,
  output logic [15:0] ir,
  output logic [4:0]  opcode,
  output logic        ir_valid,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [15:0] retired_cnt
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, ir_q, cnt_q;
  logic [15:0]  next_pc;
  logic         req;
  logic         load_ir;
  logic         retire;

  pc_next_sel u_pc_next_sel (
    .pc          (pc_q),
    .pc_src      (pc_src),
    .br_target   (br_target),
    .rind_target (rind_target),
    .next_pc     (next_pc)
  );

  // Returns outside FETCH_WAIT and advances outside HOLD fall through unused.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    load_ir = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        req = ~data_busy;
        if (req && mem_gnt) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (mem_rvalid) begin
          load_ir = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          retire  = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 16'h0000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (load_ir) ir_q <= mem_rdata;
      if (retire) begin
        pc_q  <= next_pc;
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Gate with reset so no request escapes while reset is held.
  assign mem_req     = req & reset_n;
  assign mem_addr    = pc_q;
  assign ir          = ir_q;
  assign opcode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign ir_valid    = (state_q == HOLD);
  assign pc          = pc_q;
  assign pc_plus2    = pc_q + 16'd2;
  assign retired_cnt = cnt_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter: RESET_VECTOR, 16'h0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 mem_req  output  1  instruction-fetch request to shared memory port.
REQ-005 mem_addr  output  16  byte address of fetch; equals pc while mem_req=1.
REQ-006 mem_gnt  input  1  memory accepts request this cycle.
REQ-007 mem_rdata  input  16  returned instruction word.
REQ-008 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-009 data_busy  input  1  port owned by a data access (mem_sel=1); fetch must not request.
REQ-010 advance  input  1  current instruction retires (decoder pc_enable qualified by execute).
REQ-011 pc_src  input  2  00 branch, 01 register-indirect, 10 pc+2, 11 hold.
REQ-012 br_target  input  16  branch target address.
REQ-013 rind_target  input  16  register-indirect target address.
REQ-014 ir  output  16  latched instruction register.
REQ-015 opcode  output  5  ir[15:11], feeds opcode decoder.
REQ-016 ir_valid  output  1  ir holds a fetched, unretired instruction.
REQ-017 pc  output  16  address of instruction in ir.
REQ-018 pc_plus2  output  16  pc+2, modulo 2^16, for link/writeback.
REQ-019 retired_cnt  output  16  count of retired instructions.

Function
REQ-020 FSM states SHALL be FETCH_REQ, FETCH_WAIT, HOLD; reset state FETCH_REQ.
REQ-021 FETCH_REQ: mem_req = ~data_busy; mem_gnt with mem_req=1 -> FETCH_WAIT; else stay.
REQ-022 mem_gnt while mem_req=0 SHALL be ignored.
REQ-023 FETCH_WAIT: mem_req=0; on mem_rvalid, ir<=mem_rdata, -> HOLD; else stay (no timeout).
REQ-024 mem_rvalid in FETCH_REQ or HOLD SHALL be ignored (covers stale returns after reset).
REQ-025 HOLD: ir_valid=1, ir and pc stable; on advance -> FETCH_REQ, ir_valid=0 next cycle.
REQ-026 advance outside HOLD SHALL be ignored: no PC change, no count.
REQ-027 On accepted advance, PC next: 00 br_target, 01 rind_target, 10 pc+2, 11 pc unchanged; bit 0 forced to 0.
REQ-028 pc+2 SHALL wrap 16'hFFFE -> 16'h0000.
REQ-029 retired_cnt SHALL increment by 1 per accepted advance, wrapping 16'hFFFF -> 0.
REQ-030 Zero-wait latency: gnt in cycle N, rvalid in cycle N+1 -> ir_valid=1 in cycle N+2.
REQ-031 mem_gnt and mem_rvalid in same FETCH_REQ cycle: gnt taken, rvalid ignored.
REQ-032 data_busy rising in FETCH_WAIT or HOLD SHALL not affect state.

Reset
REQ-033 While reset_n=0: pc=RESET_VECTOR, ir=16'h0000, ir_valid=0, mem_req=0, retired_cnt=0, state FETCH_REQ.
REQ-034 Reset asserted mid-fetch SHALL abort immediately; first mem_req (if data_busy=0) in first cycle after deassertion, mem_addr=RESET_VECTOR.

Structure
REQ-035 Shared package cpu_pkg SHALL hold pc_src encoding enum, fetch state enum, opcode field bounds (15:11), default RESET_VECTOR.
REQ-036 Next-PC selection SHALL be a combinational sub-module pc_next_sel (pc, pc_src, br_target, rind_target -> next_pc); all registers in instruction_fetch.

Verification
REQ-037 Reset release, data_busy=0, gnt immediate, rvalid next cycle, rdata=16'h0801 -> mem_addr=0, ir_valid cycle 2, opcode=5'b00001, pc=0.
REQ-038 HOLD, advance, pc_src=10, pc=16'hFFFE -> next mem_addr=16'h0000, retired_cnt +1.
REQ-039 HOLD, advance, pc_src=00, br_target=16'h1235 -> next mem_addr=16'h1234; pc_src=01, rind_target=16'h0040 -> 16'h0040.
REQ-040 data_busy=1 for 5 cycles in FETCH_REQ -> mem_req=0 throughout, request issues cycle after release.
REQ-041 Reset asserted in FETCH_WAIT, stale rvalid (rdata=16'hC000) 1 cycle after release -> ignored, ir_valid=0, mem_addr=RESET_VECTOR.
REQ-042 advance pulsed in FETCH_WAIT, then 3 wait cycles before rvalid -> pc and retired_cnt unchanged, ir_valid only after rvalid.
